// File: rtl/alarm_ring_controller.sv
// alarm_ring_controller: sequences the alarm buzzer from time match through ring, snooze and timeout to dismissal.
// All outputs are registered from the next-state decode, so they follow their cause by one clock.
module alarm_ring_controller #(
   parameter int CLK_HZ         = 10000,
   parameter int BEEP_HALF_CYC  = 2500,
   parameter int RING_TIMEOUT_S = 60,
   parameter int SNOOZE_S       = 300,
   parameter int SNOOZE_MAX     = 3
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        alarm_en,
   input  logic [13:0] hours,
   input  logic [13:0] minutes,
   input  logic [13:0] alarm_hours,
   input  logic [13:0] alarm_minutes,
   input  logic        stop,
   input  logic        snooze,
   output logic        beep,
   output logic        ringing,
   output logic        snoozed,
   output logic [1:0]  ring_state
);
   localparam logic [1:0] IDLE = 2'd0, RING = 2'd1, SNZ = 2'd2, DISM = 2'd3;
   localparam int PW = $clog2(CLK_HZ + 1);
   localparam int HW = $clog2(BEEP_HALF_CYC + 1);
   localparam int RW = $clog2(RING_TIMEOUT_S + 1);
   localparam int SW = $clog2(SNOOZE_S + 1);
   localparam int CW = $clog2(SNOOZE_MAX + 1);
   localparam logic [PW-1:0] PRE_LAST  = PW'(CLK_HZ - 1);
   localparam logic [HW-1:0] PH_LAST   = HW'(BEEP_HALF_CYC - 1);
   localparam logic [RW-1:0] RING_LAST = RW'(RING_TIMEOUT_S - 1);
   localparam logic [RW-1:0] RING_TOP  = RW'(RING_TIMEOUT_S);
   localparam logic [SW-1:0] SNZ_LAST  = SW'(SNOOZE_S - 1);
   localparam logic [SW-1:0] SNZ_TOP   = SW'(SNOOZE_S);
   localparam logic [CW-1:0] CNT_MAX   = CW'(SNOOZE_MAX);

   logic [1:0]    state, nxt;
   logic          match, match_q, stop_q, snooze_q;
   logic          match_rise, stop_rise, snooze_rise, sec_tick;
   logic          ring_done, snz_done, enter_ring, enter_snz;
   logic [PW-1:0] presc;
   logic [HW-1:0] ph_cnt, ph_cnt_nxt;
   logic          phase, phase_nxt;
   logic [RW-1:0] ring_t, ring_t_nxt;
   logic [SW-1:0] snz_t, snz_t_nxt;
   logic [CW-1:0] snz_cnt, snz_cnt_nxt;

   assign match       = alarm_en & (hours == alarm_hours) & (minutes == alarm_minutes);
   assign match_rise  = match & ~match_q;
   assign stop_rise   = stop & ~stop_q;
   assign snooze_rise = snooze & ~snooze_q;
   assign sec_tick    = presc == PRE_LAST;
   assign ring_done   = sec_tick & (ring_t == RING_LAST);
   assign snz_done    = sec_tick & (snz_t == SNZ_LAST);

   // Stop outranks snooze; snooze outranks a timeout landing in the same cycle.
   always_comb begin
      nxt = !alarm_en        ? IDLE :
            (state == IDLE)  ? (match_rise ? RING : IDLE) :
            (state == RING)  ? (stop_rise ? DISM :
                                snooze_rise ? ((snz_cnt < CNT_MAX) ? SNZ : DISM) :
                                ring_done ? DISM : RING) :
            (state == SNZ)   ? (stop_rise ? DISM : snz_done ? RING : SNZ) :
                               (match ? DISM : IDLE);
      enter_ring  = (nxt == RING) & (state != RING);
      enter_snz   = (nxt == SNZ) & (state != SNZ);
      ring_t_nxt  = enter_ring ? '0 :
                    ((state == RING) & sec_tick & (ring_t != RING_TOP)) ? ring_t + 1'b1 : ring_t;
      snz_t_nxt   = enter_snz ? '0 :
                    ((state == SNZ) & sec_tick & (snz_t != SNZ_TOP)) ? snz_t + 1'b1 : snz_t;
      snz_cnt_nxt = ((nxt == IDLE) | (nxt == DISM)) ? '0 :
                    ((state == RING) & (nxt == SNZ)) ? snz_cnt + 1'b1 : snz_cnt;
      ph_cnt_nxt  = enter_ring ? '0 :
                    (state == RING) ? ((ph_cnt == PH_LAST) ? '0 : ph_cnt + 1'b1) : ph_cnt;
      phase_nxt   = enter_ring ? 1'b1 :
                    ((state == RING) & (ph_cnt == PH_LAST)) ? ~phase : phase;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         match_q    <= 1'b0;
         stop_q     <= 1'b0;
         snooze_q   <= 1'b0;
         presc      <= '0;
         ph_cnt     <= '0;
         phase      <= 1'b0;
         ring_t     <= '0;
         snz_t      <= '0;
         snz_cnt    <= '0;
         beep       <= 1'b0;
         ringing    <= 1'b0;
         snoozed    <= 1'b0;
         ring_state <= IDLE;
      end else begin
         state      <= nxt;
         match_q    <= match;
         stop_q     <= stop;
         snooze_q   <= snooze;
         presc      <= sec_tick ? '0 : presc + 1'b1;
         ph_cnt     <= ph_cnt_nxt;
         phase      <= phase_nxt;
         ring_t     <= ring_t_nxt;
         snz_t      <= snz_t_nxt;
         snz_cnt    <= snz_cnt_nxt;
         beep       <= (nxt == RING) & phase_nxt;
         ringing    <= nxt == RING;
         snoozed    <= nxt == SNZ;
         ring_state <= nxt;
      end
   end
endmodule

// File: tb/tb_alarm_ring_controller.sv
// tb_alarm_ring_controller: directed scenarios then random button/time traffic, checked against a
// cycle-level behavioural model of the ring sequence.
module tb_alarm_ring_controller;
   localparam int CLK = 10, HALF = 2, RTO = 5, SNS = 3, SMAX = 2;
   logic        clk = 1'b0, rst_n = 1'b0, alarm_en = 1'b0, stop = 1'b0, snooze = 1'b0;
   logic [13:0] hours = 14'd7, minutes = 14'd29, alarm_hours = 14'd7, alarm_minutes = 14'd30;
   logic        beep, ringing, snoozed;
   logic [1:0]  ring_state;
   int tests = 0, fails = 0;
   int m_state, m_edges, m_ticks, m_snoozes, m_ring_start;
   logic m_mq, m_sq, m_zq, m_beep;

   alarm_ring_controller #(.CLK_HZ(CLK), .BEEP_HALF_CYC(HALF), .RING_TIMEOUT_S(RTO),
      .SNOOZE_S(SNS), .SNOOZE_MAX(SMAX)) dut (
      .clk(clk), .rst_n(rst_n), .alarm_en(alarm_en), .hours(hours), .minutes(minutes),
      .alarm_hours(alarm_hours), .alarm_minutes(alarm_minutes), .stop(stop), .snooze(snooze),
      .beep(beep), .ringing(ringing), .snoozed(snoozed), .ring_state(ring_state));

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [1:0] got, input logic [1:0] exp);
      tests++;
      assert (got === exp) else begin
         fails++;
         $error("FAIL %s observed=%0d expected=%0d", tag, got, exp);
      end
   endtask

   task automatic model_reset();
      m_state = 0; m_edges = 0; m_ticks = 0; m_snoozes = 0; m_ring_start = 0;
      m_mq = 0; m_sq = 0; m_zq = 0; m_beep = 0;
   endtask

   // One clock of the alarm rules, then compare every output against the model.
   task automatic cyc();
      bit match, mr, sr, zr, tick;
      int ns;
      match = alarm_en && hours == alarm_hours && minutes == alarm_minutes;
      mr = match && !m_mq; sr = stop && !m_sq; zr = snooze && !m_zq;
      tick = (m_edges % CLK) == CLK - 1;
      ns = m_state;
      if (!alarm_en) ns = 0;
      else if (m_state == 0) ns = mr ? 1 : 0;
      else if (m_state == 1) begin
         if (sr) ns = 3;
         else if (zr) begin
            if (m_snoozes < SMAX) begin ns = 2; m_snoozes++; end
            else ns = 3;
         end else if (tick && m_ticks + 1 == RTO) ns = 3;
      end else if (m_state == 2) begin
         if (sr) ns = 3;
         else if (tick && m_ticks + 1 == SNS) ns = 1;
      end else if (!match) ns = 0;
      if (ns != m_state) m_ticks = 0;
      else if (tick) m_ticks++;
      if (ns == 0 || ns == 3) m_snoozes = 0;
      if (ns == 1 && m_state != 1) m_ring_start = m_edges + 1;
      m_beep = (ns == 1) && (((m_edges + 1 - m_ring_start) / HALF) % 2 == 0);
      m_state = ns; m_edges++;
      m_mq = match; m_sq = stop; m_zq = snooze;
      @(posedge clk); #1;
      chk("beep", beep, m_beep);
      chk("ringing", ringing, m_state == 1);
      chk("snoozed", snoozed, m_state == 2);
      chk("ring_state", ring_state, 2'(m_state));
   endtask

   task automatic ring_up();
      minutes = 14'd29; cyc(); cyc();
      minutes = 14'd30; cyc();
      chk("ring_entry", ring_state, 2'd1);
      chk("ring_entry_beep", beep, 1'b1);
   endtask

   task automatic press_snooze();
      snooze = 1; cyc(); snooze = 0;
   endtask

   initial begin
      int pat[6] = '{1, 1, 0, 0, 1, 1};
      model_reset();
      repeat (3) @(posedge clk);
      #1;
      chk("rst_state", ring_state, 2'd0);
      chk("rst_beep", beep, 1'b0);
      chk("rst_ringing", ringing, 1'b0);
      chk("rst_snoozed", snoozed, 1'b0);
      @(negedge clk) rst_n = 1;
      alarm_en = 1;
      // 1: match rises, beep pattern
      ring_up();
      for (int k = 1; k < 6; k++) begin
         cyc();
         chk("beep_pattern", beep, 2'(pat[k]));
      end
      // 2: held stop dismisses, no re-ring within the minute
      stop = 1;
      cyc();
      chk("stop_dismiss", ring_state, 2'd3);
      repeat (19) cyc();
      chk("dismiss_held", ring_state, 2'd3);
      chk("dismiss_beep", beep, 1'b0);
      minutes = 14'd31; cyc();
      chk("dismiss_to_idle", ring_state, 2'd0);
      stop = 0; repeat (5) cyc();
      chk("no_rering", ring_state, 2'd0);
      // 3: two snoozes, third press dismisses
      ring_up();
      for (int n = 0; n < 2; n++) begin
         press_snooze();
         chk("snooze_enter", ring_state, 2'd2);
         for (int i = 0; i < 60 && m_state == 2; i++) cyc();
         chk("snooze_rering", ring_state, 2'd1);
      end
      press_snooze();
      chk("third_snooze_stop", ring_state, 2'd3);
      minutes = 14'd31; cyc();
      // 4: unanswered timeout
      ring_up();
      for (int i = 0; i < 100 && m_state == 1; i++) cyc();
      chk("timeout_state", ring_state, 2'd3);
      chk("timeout_beep", beep, 1'b0);
      minutes = 14'd31; cyc();
      // 5: stop and snooze together
      ring_up();
      stop = 1; snooze = 1; cyc();
      chk("both_state", ring_state, 2'd3);
      chk("both_snoozed", snoozed, 1'b0);
      stop = 0; snooze = 0; minutes = 14'd31; cyc();
      // 6: alarm_en drop, re-enable in minute, async reset mid-snooze
      ring_up();
      alarm_en = 0; cyc();
      chk("en_drop", ring_state, 2'd0);
      chk("en_drop_beep", beep, 1'b0);
      alarm_en = 1; cyc();
      chk("en_rise_ring", ring_state, 2'd1);
      press_snooze();
      chk("pre_reset_snooze", ring_state, 2'd2);
      #2 rst_n = 0;
      #1;
      chk("async_state", ring_state, 2'd0);
      chk("async_snoozed", snoozed, 1'b0);
      chk("async_ringing", ringing, 1'b0);
      chk("async_beep", beep, 1'b0);
      model_reset();
      @(negedge clk) rst_n = 1;
      // random traffic
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 199) == 0) alarm_en = ~alarm_en;
         if ($urandom_range(0, 59) == 0) minutes = 14'($urandom_range(29, 31));
         if ($urandom_range(0, 29) == 0) stop = ~stop;
         if ($urandom_range(0, 9) == 0) snooze = ~snooze;
         cyc();
      end
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
